multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle RV32I control FSM; sole driver of the ALU's ALU_control/sel inputs and sole consumer of its zero output.
- Sequences fetch/decode/execute/memory/writeback.
- Drives datapath mux selects and write strobes.
- Handshakes with the unified instruction/data memory via mem_req/mem_ready.

Parameters:
RESET_STATE, 4'd0 (FETCH), FSM encoding entered on reset

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
instr  input  32  instruction register contents (valid from DECODE onward)
zero  input  1  ALU branch condition (1 = branch taken)
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory access request
AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  output  1  store strobe (qualified by mem_ready)
IRWrite  output  1  latch fetched word into IR and PC into oldPC
PCWrite  output  1  PC update strobe
RegWrite  output  1  register file write strobe
ALUSrcA  output  2  00 PC, 01 oldPC, 10 rs1, 11 zero
ALUSrcB  output  2  00 rs2, 01 immediate, 10 constant 4
ResultSrc  output  2  00 ALUOut, 01 memory data, 10 ALU_result
ALU_control  output  4  ALU operation code
sel  output  1  immediate signed-operation select to ALU
illegal  output  1  unsupported opcode/funct decoded

Behaviour:
- Clock is CLK, reset is RST: one clock domain; reset is synchronous and active-high.
- While RST=1: state <= FETCH; every output forced to 0 in that same cycle.
- First cycle after RST falls is FETCH.
- Reset mid-instruction: the instruction is abandoned, with no further strobes.
- Outputs are combinational from state, instr, zero and mem_ready. They are glitch-free at the clock edge only.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JALR_TGT, JAL, TRAP.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU_control=0000.
  - IRWrite=PCWrite=ResultSrc(10)=mem_ready.
  - Stays in FETCH while mem_ready=0 (unbounded wait); goes to DECODE on mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALU_control=0000, sel=1 (branch/JAL target into ALUOut). Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_TGT
  - 0110111 (LUI) -> EXEC_I with ALUSrcA=11
  - 0010111 (AUIPC) -> EXEC_I with ALUSrcA=01
  - other -> illegal handling (see Optional Feature)
- ALU_control mapping (must match the ALU encoding):
  - add/addi/loads/stores/LUI/AUIPC 0000
  - sub 0001
  - and 0010, or 0011, xor 0100
  - sll 0101, srl 0110, sra 0111
  - sltu/sltiu 1000 (sel=0)
  - slt/slti 1001
  - beq 0001, bne 1010, blt 1001, bltu 1000, bge 1100, bgeu 1011
- sel: 1 in EXEC_I except sltiu, and 1 in MEM_ADDR/JALR_TGT/DECODE; 0 otherwise.
- R-type funct7 checks:
  - bit30 selects sub/sra.
  - Any other funct7 other than 0000000 is illegal.
- EXEC_R: ALUSrcA=10, ALUSrcB=00 -> ALU_WB.
- EXEC_I: ALUSrcB=01 -> ALU_WB.
- ALU_WB: RegWrite=1, ResultSrc=00 -> FETCH.
- MEM_ADDR: ALUSrcA=10, ALUSrcB=01, ALU_control=0000. Goes to MEM_READ for loads, MEM_WRITE for stores.
- MEM_READ: mem_req=1, AdrSrc=1; waits for mem_ready -> MEM_WB.
- MEM_WB: RegWrite=1, ResultSrc=01 -> FETCH.
- MEM_WRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready; waits for mem_ready -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, branch code; PCWrite=zero, ResultSrc=00 -> FETCH.
  - Undefined funct3 (010, 011) -> illegal.
- JALR_TGT: rs1+imm -> ALUOut -> JAL.
- JAL: PCWrite=1, ResultSrc=00. ALU computes oldPC+4 (ALUSrcA=01, ALUSrcB=10) -> ALU_WB.
- Latency with zero memory wait (cycles):
  - R/I/LUI/AUIPC 4
  - load 5
  - store 4
  - branch 3
  - JAL 4
  - JALR 5
- Each memory wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: illegal decode -> TRAP. TRAP holds illegal=1, all strobes 0, until RST.
- Undefined: illegal decode pulses illegal=1 for the DECODE cycle. The instruction then executes as NOP: -> FETCH, with no RegWrite/MemWrite/PCWrite beyond the fetch increment.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 in FETCH -> ALU_control=0000, sel=0 in EXEC_R; RegWrite=1 exactly in cycle 4; back to FETCH in cycle 5.
- lw x5,8(x1) with mem_ready low for 3 cycles in MEM_READ -> mem_req=1, AdrSrc=1 held 4 cycles; RegWrite with ResultSrc=01 one cycle after mem_ready; total 8 cycles.
- Each of beq/bne/blt/bge/bltu/bgeu -> ALU_control 0001/1010/1001/1100/1000/1011. PCWrite equals zero in BRANCH (zero=1 then zero=0); RegWrite never asserted.
- sltiu x1,x2,-1 -> ALU_control=1000, sel=0. slti -> 1001, sel=1. addi -> 0000, sel=1.
- Opcode 0x7F: with ILLEGAL_TRAP_EN -> illegal stays 1 for 20 cycles, no strobes, and RST recovers to FETCH. Without -> illegal 1 for one cycle, next state FETCH.
- RST asserted in MEM_WRITE with mem_ready=0 -> same-cycle all outputs 0, MemWrite never pulses, FETCH the cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and drives the ALU.
// Optional: define ILLEGAL_TRAP_EN to park in TRAP on an illegal decode; otherwise it is executed as a NOP.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  ALU_control,
    output logic        sel,
    output logic        illegal
);

    // state     | meaning
    // FETCH     | read PC word, PC+4 ; DECODE | branch target into ALUOut, dispatch
    // EXEC_R/I  | ALU op into ALUOut ; ALU_WB | write ALUOut to rd
    // MEM_*     | address, load, load writeback, store ; BRANCH | compare, conditional PC write
    // JALR_TGT  | rs1+imm into ALUOut ; JAL | PC <= ALUOut, link value ; TRAP | stuck until reset
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        ALU_WB    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        JALR_TGT  = 4'd10,
        JAL       = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_illegal;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    function automatic logic [3:0] alu_arith(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? 4'b0001 : 4'b0000;
            3'b001:  code = 4'b0101;
            3'b010:  code = 4'b1001;
            3'b011:  code = 4'b1000;
            3'b100:  code = 4'b0100;
            3'b101:  code = alt ? 4'b0111 : 4'b0110;
            3'b110:  code = 4'b0011;
            default: code = 4'b0010;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] alu_branch(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'b000:  code = 4'b0001;
            3'b001:  code = 4'b1010;
            3'b100:  code = 4'b1001;
            3'b101:  code = 4'b1100;
            3'b110:  code = 4'b1000;
            3'b111:  code = 4'b1011;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // funct7=0100000 is only meaningful for sub and sra
    always_comb begin
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: dec_illegal = !((funct7 == 7'b0000000) ||
                                  ((funct7 == 7'b0100000) &&
                                   ((funct3 == 3'b000) || (funct3 == 3'b101))));
            OP_BR: dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: dec_illegal = 1'b0;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALU_control = 4'b0000;
        sel         = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ResultSrc = mem_ready ? 2'b10 : 2'b00;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                sel     = 1'b1;
                if (dec_illegal) begin
                    illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    state_d = FETCH;
`endif
                end else begin
                    case (opcode)
                        OP_R:                     state_d = EXEC_R;
                        OP_I, OP_LUI, OP_AUIPC:   state_d = EXEC_I;
                        OP_LOAD, OP_STORE:        state_d = MEM_ADDR;
                        OP_BR:                    state_d = BRANCH;
                        OP_JAL:                   state_d = JAL;
                        OP_JALR:                  state_d = JALR_TGT;
                        default:                  state_d = FETCH;
                    endcase
                end
            end
            EXEC_R: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b00;
                ALU_control = alu_arith(funct3, funct7[5]);
                state_d     = ALU_WB;
            end
            EXEC_I: begin
                ALUSrcB = 2'b01;
                sel     = 1'b1;
                case (opcode)
                    OP_LUI:   ALUSrcA = 2'b11;
                    OP_AUIPC: ALUSrcA = 2'b01;
                    default: begin
                        ALUSrcA     = 2'b10;
                        // immediate bit 30 only selects the shift type for srai
                        ALU_control = alu_arith(funct3, (funct3 == 3'b101) && funct7[5]);
                        sel         = (funct3 != 3'b011);
                    end
                endcase
                state_d = ALU_WB;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                sel     = 1'b1;
                state_d = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
                state_d   = FETCH;
            end
            MEM_WRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = mem_ready;
                if (mem_ready) state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b00;
                ALU_control = alu_branch(funct3);
                PCWrite     = zero;
                state_d     = FETCH;
            end
            JALR_TGT: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                sel     = 1'b1;
                state_d = JAL;
            end
            JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = ALU_WB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        if (RST) begin
            mem_req     = 1'b0;
            AdrSrc      = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ResultSrc   = 2'b00;
            ALU_control = 4'b0000;
            sel         = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule
